// File: rtl/trigger_sequencer.sv
// Trigger sequencer: tracks baseline calibration, arms on a settled baseline,
// and raises a trigger when any ADC lane rises above baseline + threshold.
module trigger_sequencer #(
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int S_AXIS_TDATA_WIDTH   = 128,
    parameter int THRESHOLD            = 100,
    parameter int BASELINE_CALC_LEN    = 500000000,
    parameter int POST_TRIGGER_LEN     = 16,
    parameter int CALC_TIMEOUT         = 1000000000
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESETN,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                            S_AXIS_TVALID,
    input  logic                            I_RUN,
    input  logic                            I_RECALIB,
    input  logic [ADC_RESOLUTION_WIDTH-1:0] I_BASELINE,
    input  logic                            I_CALC_COMPLETE,
    output logic [1:0]                      O_EXEC_STATE,
    output logic                            O_TRIGGER,
    output logic [31:0]                     O_TRG_CNT,
    output logic                            O_CALC_TIMEOUT
);

    localparam int W     = ADC_RESOLUTION_WIDTH;
    localparam int LANES = S_AXIS_TDATA_WIDTH / 16;
    localparam int CW    = W + 2;
    localparam int PW    = $clog2(POST_TRIGGER_LEN + 1);

    localparam logic signed [CW-1:0] THR_C  = CW'(THRESHOLD);
    localparam logic [31:0]          BLEN_C = 32'(BASELINE_CALC_LEN);
    localparam logic [31:0]          TMO_C  = 32'(CALC_TIMEOUT);
    localparam logic [PW-1:0]        PLEN_C = PW'(POST_TRIGGER_LEN);
    localparam logic [PW-1:0]        PONE_C = PW'(1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_ARMED = 2'b01,
        ST_STOP  = 2'b10,
        ST_TRG   = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [PW-1:0] post_q, post_d;
    logic          pend_q, pend_d;
    logic          to_q, to_d;
    logic          trig_q, trig_d;
    logic [31:0]   trgcnt_q, trgcnt_d;

    logic signed [CW-1:0] level;
    logic signed [CW-1:0] smp;
    logic                 over;

    // Upper bits of each 16-bit lane carry no sample data.
    logic unused_tdata;
    assign unused_tdata = ^S_AXIS_TDATA;

    // Widen by two bits so baseline + threshold cannot wrap.
    assign level = {{2{I_BASELINE[W-1]}}, I_BASELINE} + THR_C;

    // Current beat is "over" if any lane exceeds the trigger level.
    always_comb begin
        over = 1'b0;
        smp  = '0;
        for (int k = 0; k < LANES; k++) begin
            smp = {{2{S_AXIS_TDATA[16*k+W-1]}}, S_AXIS_TDATA[16*k +: W]};
            if (S_AXIS_TVALID && (smp > level)) begin
                over = 1'b1;
            end
        end
    end

    // Next-state and counter logic; I_RUN low overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        post_d   = post_q;
        pend_d   = pend_q;
        to_d     = to_q;
        trig_d   = 1'b0;
        trgcnt_d = trgcnt_q;
        if (!I_RUN) begin
            state_d = ST_STOP;
        end else begin
            unique case (state_q)
                ST_STOP: begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    to_d    = 1'b0;
                    pend_d  = 1'b0;
                end
                ST_INIT: begin
                    if (S_AXIS_TVALID && (cnt_q != BLEN_C)) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                    if (tmo_q != TMO_C) begin
                        tmo_d = tmo_q + 32'd1;
                    end
                    if (tmo_d == TMO_C) begin
                        to_d = 1'b1;
                    end
                    if ((cnt_q == BLEN_C) && I_CALC_COMPLETE) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (over) begin
                        state_d  = ST_TRG;
                        post_d   = PLEN_C;
                        trig_d   = 1'b1;
                        trgcnt_d = trgcnt_q + 32'd1;
                    end else if (I_RECALIB || pend_q) begin
                        state_d = ST_INIT;
                        cnt_d   = '0;
                        tmo_d   = '0;
                        pend_d  = 1'b0;
                    end
                end
                ST_TRG: begin
                    if (I_RECALIB) begin
                        pend_d = 1'b1;
                    end
                    if (over) begin
                        post_d = PLEN_C;
                    end else if (S_AXIS_TVALID) begin
                        if (post_q == PONE_C) begin
                            state_d = ST_ARMED;
                        end else begin
                            post_d = post_q - PONE_C;
                        end
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q  <= ST_STOP;
            cnt_q    <= '0;
            tmo_q    <= '0;
            post_q   <= '0;
            pend_q   <= 1'b0;
            to_q     <= 1'b0;
            trig_q   <= 1'b0;
            trgcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            post_q   <= post_d;
            pend_q   <= pend_d;
            to_q     <= to_d;
            trig_q   <= trig_d;
            trgcnt_q <= trgcnt_d;
        end
    end

    assign O_EXEC_STATE   = state_q;
    assign O_TRIGGER      = trig_q;
    assign O_TRG_CNT      = trgcnt_q;
    assign O_CALC_TIMEOUT = to_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer with small calibration lengths.
module tb_trigger_sequencer;

    localparam logic [1:0] S_INIT  = 2'b00;
    localparam logic [1:0] S_ARMED = 2'b01;
    localparam logic [1:0] S_STOP  = 2'b10;
    localparam logic [1:0] S_TRG   = 2'b11;

    logic         clk;
    logic         rst_n;
    logic [127:0] tdata;
    logic         tvalid;
    logic         run;
    logic         recalib;
    logic [11:0]  baseline;
    logic         complete;
    logic [1:0]   state;
    logic         trig;
    logic [31:0]  trgcnt;
    logic         tmo;

    int nchk = 0;
    int nerr = 0;
    int n;

    trigger_sequencer #(
        .ADC_RESOLUTION_WIDTH(12),
        .S_AXIS_TDATA_WIDTH(128),
        .THRESHOLD(100),
        .BASELINE_CALC_LEN(8),
        .POST_TRIGGER_LEN(4),
        .CALC_TIMEOUT(20)
    ) dut (
        .AXIS_ACLK(clk),
        .AXIS_ARESETN(rst_n),
        .S_AXIS_TDATA(tdata),
        .S_AXIS_TVALID(tvalid),
        .I_RUN(run),
        .I_RECALIB(recalib),
        .I_BASELINE(baseline),
        .I_CALC_COMPLETE(complete),
        .O_EXEC_STATE(state),
        .O_TRIGGER(trig),
        .O_TRG_CNT(trgcnt),
        .O_CALC_TIMEOUT(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(int k, logic [11:0] v);
        logic [127:0] d;
        d = '0;
        d[16*k +: 12] = v;
        return d;
    endfunction

    initial begin
        rst_n    = 1'b0;
        tdata    = '0;
        tvalid   = 1'b0;
        run      = 1'b0;
        recalib  = 1'b0;
        baseline = 12'd100;
        complete = 1'b0;
        #13;
        check("rst_state", 32'(state), 32'(S_STOP));
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_cnt", trgcnt, 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_stop", 32'(state), 32'(S_STOP));

        // Calibration: 8 beats counted, then ARMED.
        run    = 1'b1;
        tvalid = 1'b1;
        tick();
        check("to_init", 32'(state), 32'(S_INIT));
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) complete = 1'b1;
            tick();
        end
        check("init_8beats", 32'(state), 32'(S_INIT));
        tick();
        check("armed", 32'(state), 32'(S_ARMED));

        // Level must not wrap: 2047 is not above 2000 + 100.
        baseline = 12'd2000;
        tdata    = mk(0, 12'h7FF);
        tick();
        check("nowrap", 32'(state), 32'(S_ARMED));
        baseline = 12'd100;
        tdata    = mk(1, 12'h800);
        tick();
        check("negative", 32'(state), 32'(S_ARMED));
        tdata = mk(3, 12'd200);
        tick();
        check("at_level", 32'(state), 32'(S_ARMED));
        check("at_level_trig", 32'(trig), 32'd0);
        tdata = mk(3, 12'd201);
        tick();
        check("trg_entry", 32'(state), 32'(S_TRG));
        check("trg_pulse", 32'(trig), 32'd1);
        check("trg_cnt1", trgcnt, 32'd1);

        // Post-trigger window with a reload and a hold cycle.
        tdata = '0;
        tick();
        check("pulse_end", 32'(trig), 32'd0);
        check("post_u1", 32'(state), 32'(S_TRG));
        tick();
        check("post_u2", 32'(state), 32'(S_TRG));
        tvalid = 1'b0;
        tick();
        check("post_hold", 32'(state), 32'(S_TRG));
        tvalid = 1'b1;
        tdata  = mk(2, 12'd300);
        tick();
        check("reload", 32'(state), 32'(S_TRG));
        check("reload_cnt", trgcnt, 32'd1);
        tdata = '0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("post_tail", 32'(state), 32'(S_TRG));
        end
        tick();
        check("post_exit", 32'(state), 32'(S_ARMED));

        // Recalibration requested during TRG is deferred.
        tdata = mk(5, 12'd250);
        tick();
        check("trg2", 32'(state), 32'(S_TRG));
        check("trg_cnt2", trgcnt, 32'd2);
        tdata   = '0;
        recalib = 1'b1;
        tick();
        recalib = 1'b0;
        check("recal_in_trg", 32'(state), 32'(S_TRG));
        tick();
        tick();
        check("recal_wait", 32'(state), 32'(S_TRG));
        tick();
        check("recal_armed", 32'(state), 32'(S_ARMED));
        tick();
        check("recal_init", 32'(state), 32'(S_INIT));

        // Timeout after 20 cycles in INIT without completion.
        complete = 1'b0;
        for (int i = 1; i <= 19; i++) tick();
        check("tmo_pre", 32'(tmo), 32'd0);
        tick();
        check("tmo_set", 32'(tmo), 32'd1);
        check("tmo_state", 32'(state), 32'(S_INIT));
        tick();
        check("tmo_sticky", 32'(tmo), 32'd1);
        run = 1'b0;
        tick();
        check("tmo_stop", 32'(state), 32'(S_STOP));
        run = 1'b1;
        tick();
        check("tmo_clear", 32'(tmo), 32'd0);
        check("tmo_reinit", 32'(state), 32'(S_INIT));

        // I_RUN low beats a coincident over beat.
        complete = 1'b1;
        n = 0;
        while (state != S_ARMED && n < 20) begin
            tick();
            n++;
        end
        check("init_len", n, 32'd9);
        run   = 1'b0;
        tdata = mk(3, 12'd201);
        tick();
        check("run_prio", 32'(state), 32'(S_STOP));
        check("run_prio_trig", 32'(trig), 32'd0);
        check("run_prio_cnt", trgcnt, 32'd2);

        // Asynchronous reset in the middle of TRG.
        run   = 1'b1;
        tdata = '0;
        tick();
        n = 0;
        while (state != S_ARMED && n < 20) begin
            tick();
            n++;
        end
        check("rearm", 32'(state), 32'(S_ARMED));
        tdata = mk(7, 12'd500);
        tick();
        check("trg3", 32'(state), 32'(S_TRG));
        tdata = '0;
        run   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'(S_STOP));
        check("abort_cnt", trgcnt, 32'd0);
        check("abort_trig", 32'(trig), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst", 32'(state), 32'(S_STOP));
        run = 1'b1;
        tick();
        check("post_rst_run", 32'(state), 32'(S_INIT));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 SHALL have parameter ADC_RESOLUTION_WIDTH, default 12, ADC sample width.
REQ-002 SHALL have parameter S_AXIS_TDATA_WIDTH, default 128, stream width; each 16-bit lane carries one sample.
REQ-003 SHALL have parameter THRESHOLD, default 100, trigger level above baseline in ADC counts.
REQ-004 SHALL have parameter BASELINE_CALC_LEN, default 5E8, minimum valid beats spent in INIT.
REQ-005 SHALL have parameter POST_TRIGGER_LEN, default 16, below-threshold beats kept in TRG after the last over-threshold beat.
REQ-006 SHALL have parameter CALC_TIMEOUT, default 1E9, clock cycles allowed in INIT before timeout.
REQ-007 AXIS_ACLK  in  1  the only clock; one clock, all logic on rising edge.
REQ-008 AXIS_ARESETN  in  1  reset, asynchronous, active-low.
REQ-009 S_AXIS_TDATA  in  S_AXIS_TDATA_WIDTH  ADC stream.
REQ-010 S_AXIS_TVALID  in  1  beat valid.
REQ-011 I_RUN  in  1  level enable; low forces STOP.
REQ-012 I_RECALIB  in  1  single-cycle baseline recalibration request.
REQ-013 I_BASELINE  in  ADC_RESOLUTION_WIDTH  signed baseline from the baseline calculator.
REQ-014 I_CALC_COMPLETE  in  1  baseline calculator completion flag (sticky).
REQ-015 O_EXEC_STATE  out  2  state encoding driven to the datapath.
REQ-016 O_TRIGGER  out  1  one-cycle pulse on TRG entry.
REQ-017 O_TRG_CNT  out  32  number of TRG entries.
REQ-018 O_CALC_TIMEOUT  out  1  sticky INIT timeout flag.

Function
REQ-019 States SHALL encode as INIT=2'b00, ARMED=2'b01, STOP=2'b10, TRG=2'b11; O_EXEC_STATE SHALL equal the state register.
REQ-020 Lane k sample SHALL be S_AXIS_TDATA[16k +: ADC_RESOLUTION_WIDTH], signed.
REQ-021 A beat SHALL be "over" when TVALID=1 and any lane sample > I_BASELINE + THRESHOLD, compared at ADC_RESOLUTION_WIDTH+2 signed bits (no wrap).
REQ-022 Over detection SHALL be combinational on the current beat; the state changes at the next rising edge (1-cycle latency beat->O_EXEC_STATE).
REQ-023 I_RUN=0 SHALL move any state to STOP at the next edge, highest priority.
REQ-024 STOP with I_RUN=1 SHALL go to INIT and clear the INIT beat counter, the timeout cycle counter and O_CALC_TIMEOUT.
REQ-025 INIT SHALL count TVALID beats, saturating at BASELINE_CALC_LEN; exit to ARMED when count = BASELINE_CALC_LEN and I_CALC_COMPLETE=1.
REQ-026 INIT SHALL count clock cycles; on reaching CALC_TIMEOUT, O_CALC_TIMEOUT SHALL set and remain set; the state stays INIT.
REQ-027 ARMED: over beat -> TRG, load post counter with POST_TRIGGER_LEN, O_TRIGGER=1 for that one edge, O_TRG_CNT+1.
REQ-028 ARMED: I_RECALIB=1 or a pending recalibration, with no over beat -> INIT, counters cleared; an over beat takes priority.
REQ-029 TRG: over beat reloads the post counter; a valid non-over beat decrements it; a non-over beat with counter=1 -> ARMED; TVALID=0 holds.
REQ-030 I_RECALIB in TRG SHALL set a pending flag, consumed on the ARMED->INIT transition.
REQ-031 O_TRG_CNT SHALL wrap 0xFFFFFFFF->0; it is not cleared by STOP.
REQ-032 Registered outputs only; no combinational path input->output.

Reset
REQ-033 On AXIS_ARESETN=0 (asynchronous): state=STOP, O_EXEC_STATE=2'b10, O_TRIGGER=0, O_TRG_CNT=0, O_CALC_TIMEOUT=0, all counters and the pending flag 0.
REQ-034 Reset asserted mid-TRG SHALL abort immediately; after release the block goes INIT only via I_RUN=1.

Verification
REQ-035 Reset, I_RUN=1, BASELINE_CALC_LEN=8, TVALID=1, I_CALC_COMPLETE=1 from cycle 3 -> STOP, INIT, ARMED after the 8th beat.
REQ-036 ARMED, baseline 100, THRESHOLD 100, one beat lane3=201 -> TRG next edge, O_TRIGGER one cycle, O_TRG_CNT=1; lane=200 -> no trigger.
REQ-037 POST_TRIGGER_LEN=4: over, 2 under, over, 4 under -> TRG held, ARMED after the last of the 4 unders.
REQ-038 I_RECALIB during TRG -> stays TRG; on exit goes ARMED then INIT one cycle later.
REQ-039 CALC_TIMEOUT=20, I_CALC_COMPLETE=0 -> O_CALC_TIMEOUT=1 at cycle 20, state INIT; I_RUN 0->1 clears it.
REQ-040 I_RUN=0 coincident with an over beat in ARMED -> STOP, no O_TRIGGER, O_TRG_CNT unchanged.
